fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 25 ++
 rtl/fifo_wr_arbiter_cnt.sv | 19 +
 rtl/fifo_wr_arbiter.sv | 147 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the two-requester FIFO write arbiter: state
// encodings, the default data width, the burst counter width and a
// saturating increment used by the burst counter.
package fifo_arb_pkg;

    localparam int DW_DEFAULT = 8;
    localparam int BCNT_W     = 4;

    // Arbiter states: IDLE, SERVE0, SERVE1 (kept as plain constants so
    // older tools and netlists see a fixed two-bit encoding).
    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE   = 2'd0;
    localparam arb_state_t SERVE0 = 2'd1;
    localparam arb_state_t SERVE1 = 2'd2;

    // Count up by one but never beyond lim.
    function automatic logic [BCNT_W-1:0] sat_inc(
        input logic [BCNT_W-1:0] v,
        input logic [BCNT_W-1:0] lim
    );
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_cnt.sv
// arb_grant_cnt: 8-bit wrapping counter of grants given to one requester.
// Only instantiated when FIFO_ARB_STATS_EN is defined.
module arb_grant_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic [7:0] count
);

    // Bump once per grant pulse; rolls over from 255 to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 8'd0;
        end else if (inc) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: merges two word-at-a-time requesters onto one FIFO write
// port. Arbitration runs only in cycles with no write strobe and a non-full
// FIFO, so a full flag raised by a write is always seen before the next one.
// A burst counter lets one requester take up to MAX_BURST consecutive words
// while the other waits, after which the other side is served.
// Optional build macro FIFO_ARB_STATS_EN adds per-requester grant counters
// on outputs gcnt0/gcnt1.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DW        = DW_DEFAULT,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [DW-1:0] data0,
    output logic          gnt0,
    input  logic          req1,
    input  logic [DW-1:0] data1,
    output logic          gnt1,
    output logic          fifo_wr,
    output logic [DW-1:0] fifo_din,
    input  logic          fifo_full,
    output logic          last_src
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [7:0]    gcnt0,
    output logic [7:0]    gcnt1
`endif
);

    localparam logic [BCNT_W-1:0] MAX_B = BCNT_W'(MAX_BURST);
    localparam logic [BCNT_W-1:0] ONE_B = BCNT_W'(1);

    arb_state_t        state;
    arb_state_t        state_d;
    logic [BCNT_W-1:0] bcnt;
    logic [BCNT_W-1:0] bcnt_d;
    logic              take0;
    logic              take1;

    // Decide next grant, state and burst count; nothing moves while a
    // write is in flight or the FIFO is full.
    always_comb begin
        take0   = 1'b0;
        take1   = 1'b0;
        state_d = state;
        bcnt_d  = bcnt;
        if (!fifo_wr && !fifo_full) begin
            case (state)
                IDLE: begin
                    if (req0 && req1) begin
                        take0 = last_src;
                        take1 = !last_src;
                    end else begin
                        take0 = req0;
                        take1 = req1;
                    end
                    if (take0) begin
                        state_d = SERVE0;
                        bcnt_d  = ONE_B;
                    end else if (take1) begin
                        state_d = SERVE1;
                        bcnt_d  = ONE_B;
                    end
                end
                SERVE0: begin
                    if (req0 && (bcnt < MAX_B || !req1)) begin
                        take0  = 1'b1;
                        bcnt_d = sat_inc(bcnt, MAX_B);
                    end else if (req1) begin
                        take1   = 1'b1;
                        state_d = SERVE1;
                        bcnt_d  = ONE_B;
                    end else begin
                        state_d = IDLE;
                        bcnt_d  = '0;
                    end
                end
                SERVE1: begin
                    if (req1 && (bcnt < MAX_B || !req0)) begin
                        take1  = 1'b1;
                        bcnt_d = sat_inc(bcnt, MAX_B);
                    end else if (req0) begin
                        take0   = 1'b1;
                        state_d = SERVE0;
                        bcnt_d  = ONE_B;
                    end else begin
                        state_d = IDLE;
                        bcnt_d  = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    bcnt_d  = '0;
                end
            endcase
        end
    end

    // Register the decision; grant, write strobe, data and source all
    // update on the same edge, and the data word is held between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bcnt     <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            fifo_wr  <= 1'b0;
            fifo_din <= '0;
            last_src <= 1'b1;
        end else begin
            state   <= state_d;
            bcnt    <= bcnt_d;
            gnt0    <= take0;
            gnt1    <= take1;
            fifo_wr <= take0 | take1;
            if (take0) begin
                fifo_din <= data0;
                last_src <= 1'b0;
            end else if (take1) begin
                fifo_din <= data1;
                last_src <= 1'b1;
            end
        end
    end

`ifdef FIFO_ARB_STATS_EN
    arb_grant_cnt u_gcnt0 (
        .clk   (clk),
        .rst   (rst),
        .inc   (gnt0),
        .count (gcnt0)
    );

    arb_grant_cnt u_gcnt1 (
        .clk   (clk),
        .rst   (rst),
        .inc   (gnt1),
        .count (gcnt1)
    );
`else
    // No grant statistics in this build.
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (DW=8, MAX_BURST=4). Vectors carry one
// cycle of inputs plus the outputs expected after the following edge;
// expectations are queued when a vector is driven and popped when the
// outputs are sampled.
module tb_fifo_wr_arbiter;

    typedef struct {
        logic       rst;
        logic       req0;
        logic       req1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       full;
        logic       eg0;
        logic       eg1;
        logic       ewr;
        logic [7:0] edin;
        logic       elast;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic       gnt0;
    logic       req1 = 1'b0;
    logic [7:0] data1 = 8'h00;
    logic       gnt1;
    logic       fifo_wr;
    logic [7:0] fifo_din;
    logic       fifo_full = 1'b0;
    logic       last_src;
`ifdef FIFO_ARB_STATS_EN
    logic [7:0] gcnt0;
    logic [7:0] gcnt1;
`endif

    int total = 0;
    int bad   = 0;
    int step  = 0;

    vec_t vecs[$];
    vec_t sb_q[$];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .DW        (8),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .data0     (data0),
        .gnt0      (gnt0),
        .req1      (req1),
        .data1     (data1),
        .gnt1      (gnt1),
        .fifo_wr   (fifo_wr),
        .fifo_din  (fifo_din),
        .fifo_full (fifo_full),
        .last_src  (last_src)
`ifdef FIFO_ARB_STATS_EN
        ,
        .gcnt0     (gcnt0),
        .gcnt1     (gcnt1)
`endif
    );

    function automatic vec_t mk(
        input logic r, input logic q0, input logic q1,
        input logic [7:0] d0, input logic [7:0] d1, input logic full,
        input logic g0, input logic g1, input logic [7:0] din, input logic last
    );
        vec_t v;
        v.rst   = r;
        v.req0  = q0;
        v.req1  = q1;
        v.d0    = d0;
        v.d1    = d1;
        v.full  = full;
        v.eg0   = g0;
        v.eg1   = g1;
        v.ewr   = g0 | g1;
        v.edin  = din;
        v.elast = last;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst       = v.rst;
        req0      = v.req0;
        req1      = v.req1;
        data0     = v.d0;
        data1     = v.d1;
        fifo_full = v.full;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name);
        vec_t e;
        total++;
        step++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL %s step %0d: no expected entry queued", name, step);
        end else begin
            e = sb_q.pop_front();
            if ({gnt0, gnt1, fifo_wr, fifo_din, last_src} !==
                {e.eg0, e.eg1, e.ewr, e.edin, e.elast}) begin
                bad++;
                $display("[TB] FAIL %s step %0d: got g0=%b g1=%b wr=%b din=%h last=%b, want g0=%b g1=%b wr=%b din=%h last=%b",
                         name, step, gnt0, gnt1, fifo_wr, fifo_din, last_src,
                         e.eg0, e.eg1, e.ewr, e.edin, e.elast);
            end
        end
    endtask

    task automatic runVec(input string name, input vec_t v);
        applyStimulus(v);
        checkOutput(name);
    endtask

`ifdef FIFO_ARB_STATS_EN
    task automatic checkCount(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask
`endif

    // Watchdog so a stuck run still ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset with both requesting, then both held: 0,0,0,0,1,1,1,1,0.
        vecs.push_back(mk(1, 1, 1, 8'hA5, 8'h3C, 0, 0, 0, 8'h00, 1));
        vecs.push_back(mk(1, 1, 1, 8'hA5, 8'h3C, 0, 0, 0, 8'h00, 1));
        for (int k = 0; k < 4; k++) begin
            vecs.push_back(mk(0, 1, 1, 8'hA5, 8'h3C, 0, 1, 0, 8'hA5, 0));
            vecs.push_back(mk(0, 1, 1, 8'hA5, 8'h3C, 0, 0, 0, 8'hA5, 0));
        end
        for (int k = 0; k < 4; k++) begin
            vecs.push_back(mk(0, 1, 1, 8'hA5, 8'h3C, 0, 0, 1, 8'h3C, 1));
            vecs.push_back(mk(0, 1, 1, 8'hA5, 8'h3C, 0, 0, 0, 8'h3C, 1));
        end
        vecs.push_back(mk(0, 1, 1, 8'hA5, 8'h3C, 0, 1, 0, 8'hA5, 0));

        // Single requester past the burst limit, then the other arrives.
        vecs.push_back(mk(1, 0, 0, 8'hA5, 8'h5A, 0, 0, 0, 8'h00, 1));
        for (int k = 0; k < 6; k++) begin
            if (k > 0) vecs.push_back(mk(0, 1, 0, 8'hA5, 8'h5A, 0, 0, 0, 8'hA5, 0));
            vecs.push_back(mk(0, 1, 0, 8'hA5, 8'h5A, 0, 1, 0, 8'hA5, 0));
        end
        vecs.push_back(mk(0, 1, 1, 8'hA5, 8'h5A, 0, 0, 0, 8'hA5, 0));
        vecs.push_back(mk(0, 1, 1, 8'hA5, 8'h5A, 0, 0, 1, 8'h5A, 1));
        vecs.push_back(mk(0, 1, 0, 8'hA5, 8'h5A, 0, 0, 0, 8'h5A, 1));
        vecs.push_back(mk(0, 1, 0, 8'hA5, 8'h5A, 0, 1, 0, 8'hA5, 0));
        vecs.push_back(mk(0, 0, 0, 8'hA5, 8'h5A, 0, 0, 0, 8'hA5, 0));
        vecs.push_back(mk(0, 0, 0, 8'hA5, 8'h5A, 0, 0, 0, 8'hA5, 0));
        vecs.push_back(mk(0, 0, 1, 8'hA5, 8'hC3, 0, 0, 1, 8'hC3, 1));
        vecs.push_back(mk(0, 1, 0, 8'h0F, 8'hC3, 0, 0, 0, 8'hC3, 1));
        vecs.push_back(mk(0, 1, 0, 8'h0F, 8'hC3, 0, 1, 0, 8'h0F, 0));

        $display("[TB] table vectors: %0d", vecs.size());
        foreach (vecs[i]) runVec("table", vecs[i]);

        // FIFO full stall: two grants to 0, full for 5 cycles, then two
        // more to 0 before switching to 1.
        runVec("stall", mk(1, 1, 1, 8'h77, 8'h88, 0, 0, 0, 8'h00, 1));
        runVec("stall", mk(0, 1, 1, 8'h77, 8'h88, 0, 1, 0, 8'h77, 0));
        runVec("stall", mk(0, 1, 1, 8'h77, 8'h88, 0, 0, 0, 8'h77, 0));
        runVec("stall", mk(0, 1, 1, 8'h77, 8'h88, 0, 1, 0, 8'h77, 0));
        for (int k = 0; k < 5; k++)
            runVec("stall_full", mk(0, 1, 1, 8'h77, 8'h88, 1, 0, 0, 8'h77, 0));
        runVec("stall", mk(0, 1, 1, 8'h77, 8'h88, 0, 1, 0, 8'h77, 0));
        runVec("stall", mk(0, 1, 1, 8'h77, 8'h88, 0, 0, 0, 8'h77, 0));
        runVec("stall", mk(0, 1, 1, 8'h77, 8'h88, 0, 1, 0, 8'h77, 0));
        runVec("stall", mk(0, 1, 1, 8'h77, 8'h88, 0, 0, 0, 8'h77, 0));
        runVec("stall", mk(0, 1, 1, 8'h77, 8'h88, 0, 0, 1, 8'h88, 1));

        // Reset asserted during a gnt1 cycle, then requester 0 wins.
        runVec("midrst", mk(1, 1, 1, 8'h11, 8'h22, 0, 0, 0, 8'h00, 1));
        for (int k = 0; k < 4; k++) begin
            runVec("midrst", mk(0, 1, 1, 8'h11, 8'h22, 0, 1, 0, 8'h11, 0));
            runVec("midrst", mk(0, 1, 1, 8'h11, 8'h22, 0, 0, 0, 8'h11, 0));
        end
        runVec("midrst", mk(0, 1, 1, 8'h11, 8'h22, 0, 0, 1, 8'h22, 1));
        runVec("midrst_rst", mk(1, 1, 1, 8'h11, 8'h22, 0, 0, 0, 8'h00, 1));
        runVec("midrst_after", mk(0, 1, 1, 8'h11, 8'h22, 0, 1, 0, 8'h11, 0));

`ifdef FIFO_ARB_STATS_EN
        // Grant statistics: 10 to requester 0, 3 to requester 1.
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; fifo_full = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; req0 = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        req0 = 1'b0; req1 = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        req1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkCount("gcnt0_10", gcnt0, 8'd10);
        checkCount("gcnt1_3", gcnt1, 8'd3);

        // 256 grants to requester 0 wrap its counter back to zero.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req0 = 1'b1;
        repeat (512) @(posedge clk);
        #1;
        req0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkCount("gcnt0_wrap", gcnt0, 8'd0);
        checkCount("gcnt1_zero", gcnt1, 8'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
